// File: rtl/uart_mon_pkg.sv
// Shared types and helpers for the UART frame monitor: parity mode, FSM states, bit-period math.
package uart_mon_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Clocks per bit, rounded to nearest.
  function automatic int calc_cpb(input real clk_mhz, input int baud);
    return int'($rtoi(clk_mhz * 1.0e6 / real'(baud) + 0.5));
  endfunction

endpackage

// File: rtl/uart_frame_monitor_if.sv
// Frame output port of the UART monitor: valid/ready handshake plus decoded data and error flags.
interface uart_frame_monitor_if #(
  parameter int DATA_BITS = 8
);
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_BITS-1:0] out_data;
  logic                 out_parity_err;
  logic                 out_frame_err;
  logic                 out_break;

  modport master (
    output out_valid, out_data, out_parity_err, out_frame_err, out_break,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_parity_err, out_frame_err, out_break,
    output out_ready
  );
endinterface

// File: rtl/uart_mon_bit_timer.sv
// Loadable down-counter; tick is high while the count sits at zero.
module uart_mon_bit_timer #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tick
);
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: load wins, otherwise count down and hold at zero.
  always_comb begin
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != {WIDTH{1'b0}}) begin
      cnt_d = cnt_q - WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= {WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == {WIDTH{1'b0}});
endmodule

// File: rtl/uart_frame_monitor.sv
// UART receive-side frame monitor with glitch rejection, parity/framing/break flags and counters.
// Optional input synchroniser enabled by defining UART_MON_SYNC_EN.
module uart_frame_monitor
  import uart_mon_pkg::*;
#(
  parameter real     CLK_FREQ_MHZ = 100.0,
  parameter int      BAUD_RATE    = 115200,
  parameter int      DATA_BITS    = 8,
  parameter parity_t PARITY       = PAR_NONE,
  parameter int      STOP_BITS    = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        uart_rx,
  uart_frame_monitor_if.master        out_if,
  output logic                        overrun,
  input  logic                        clr_overrun,
  output logic [15:0]                 frame_count,
  output logic [15:0]                 error_count
);
  localparam int CPB     = calc_cpb(CLK_FREQ_MHZ, BAUD_RATE);
  localparam int HALF    = CPB >> 1;
  localparam int CW      = (CPB > 1) ? $clog2(CPB) : 1;
  localparam bit HAS_PAR = (PARITY != PAR_NONE);

  function automatic logic par_mismatch(input logic [DATA_BITS-1:0] d, input logic p);
    return (PARITY == PAR_ODD) ? ~(^d ^ p) : (^d ^ p);
  endfunction

  logic rx_s;
`ifdef UART_MON_SYNC_EN
  logic [1:0] sync_q;
  logic [1:0] sync_d;

  // Two-flop synchroniser, idles high.
  always_comb begin
    sync_d = {sync_q[0], uart_rx};
  end

  // Synchroniser registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end
  assign rx_s = sync_q[1];
`else
  assign rx_s = uart_rx;
`endif

  logic          tmr_load_s;
  logic [CW-1:0] tmr_val_s;
  logic          tmr_tick_s;

  uart_mon_bit_timer #(.WIDTH(CW)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .tick     (tmr_tick_s)
  );

  state_t               state_q, state_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  logic                 par_err_q, par_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 first_stop_q, first_stop_d;
  logic                 done_q, done_d;
  logic                 rx_prev_q;
  logic                 start_s;

  logic                 out_valid_q, out_valid_d;
  logic [DATA_BITS-1:0] out_data_q, out_data_d;
  logic                 out_perr_q, out_perr_d;
  logic                 out_ferr_q, out_ferr_d;
  logic                 out_brk_q, out_brk_d;
  logic                 overrun_q, overrun_d;
  logic [15:0]          frame_count_q, frame_count_d;
  logic [15:0]          error_count_q, error_count_d;
  logic                 drop_s;

  assign start_s = rx_prev_q & ~rx_s;

  // Receive FSM: every sample point reloads the bit timer with a full bit period.
  always_comb begin
    state_d      = state_q;
    bit_idx_d    = bit_idx_q;
    stop_idx_d   = stop_idx_q;
    shift_d      = shift_q;
    par_bit_d    = par_bit_q;
    par_err_d    = par_err_q;
    frame_err_d  = frame_err_q;
    first_stop_d = first_stop_q;
    done_d       = 1'b0;
    tmr_load_s   = 1'b0;
    tmr_val_s    = CW'(CPB - 1);
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          state_d    = ST_START;
          tmr_load_s = 1'b1;
          tmr_val_s  = CW'(HALF - 1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (!tmr_tick_s) begin
          state_d = ST_START;
        end else if (rx_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d      = ST_DATA;
          tmr_load_s   = 1'b1;
          bit_idx_d    = 4'd0;
          stop_idx_d   = 1'b0;
          par_bit_d    = 1'b0;
          par_err_d    = 1'b0;
          frame_err_d  = 1'b0;
          first_stop_d = 1'b1;
        end
      end
      ST_DATA: begin
        if (tmr_tick_s) begin
          tmr_load_s = 1'b1;
          shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_idx_d  = bit_idx_q + 4'd1;
          if (bit_idx_q == 4'(DATA_BITS - 1)) begin
            state_d = HAS_PAR ? ST_PARITY : ST_STOP;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (tmr_tick_s) begin
          tmr_load_s = 1'b1;
          par_bit_d  = rx_s;
          par_err_d  = par_mismatch(shift_q, rx_s);
          state_d    = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (tmr_tick_s) begin
          tmr_load_s = 1'b1;
          if (!rx_s) begin
            frame_err_d = 1'b1;
          end else begin
            frame_err_d = frame_err_q;
          end
          if (stop_idx_q == 1'b0) begin
            first_stop_d = rx_s;
          end else begin
            first_stop_d = first_stop_q;
          end
          // Leave as soon as the last stop bit is sampled so a back-to-back start is seen.
          if (stop_idx_q == 1'(STOP_BITS - 1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d    = ST_STOP;
            stop_idx_d = 1'b1;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output register, handshake, overrun and counters.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_perr_d    = out_perr_q;
    out_ferr_d    = out_ferr_q;
    out_brk_d     = out_brk_q;
    frame_count_d = frame_count_q;
    error_count_d = error_count_q;
    drop_s        = 1'b0;
    if (done_q) begin
      frame_count_d = frame_count_q + 16'd1;
      if (par_err_q | frame_err_q) begin
        error_count_d = error_count_q + 16'd1;
      end else begin
        error_count_d = error_count_q;
      end
      if (!out_valid_q || out_if.out_ready) begin
        out_valid_d = 1'b1;
        out_data_d  = shift_q;
        out_perr_d  = par_err_q;
        out_ferr_d  = frame_err_q;
        out_brk_d   = (shift_q == {DATA_BITS{1'b0}}) && (!HAS_PAR || !par_bit_q) && !first_stop_q;
      end else begin
        drop_s = 1'b1;
      end
    end else if (out_valid_q && out_if.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (drop_s) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      bit_idx_q     <= 4'd0;
      stop_idx_q    <= 1'b0;
      shift_q       <= {DATA_BITS{1'b0}};
      par_bit_q     <= 1'b0;
      par_err_q     <= 1'b0;
      frame_err_q   <= 1'b0;
      first_stop_q  <= 1'b1;
      done_q        <= 1'b0;
      rx_prev_q     <= 1'b1;
      out_valid_q   <= 1'b0;
      out_data_q    <= {DATA_BITS{1'b0}};
      out_perr_q    <= 1'b0;
      out_ferr_q    <= 1'b0;
      out_brk_q     <= 1'b0;
      overrun_q     <= 1'b0;
      frame_count_q <= 16'd0;
      error_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      bit_idx_q     <= bit_idx_d;
      stop_idx_q    <= stop_idx_d;
      shift_q       <= shift_d;
      par_bit_q     <= par_bit_d;
      par_err_q     <= par_err_d;
      frame_err_q   <= frame_err_d;
      first_stop_q  <= first_stop_d;
      done_q        <= done_d;
      rx_prev_q     <= rx_s;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_perr_q    <= out_perr_d;
      out_ferr_q    <= out_ferr_d;
      out_brk_q     <= out_brk_d;
      overrun_q     <= overrun_d;
      frame_count_q <= frame_count_d;
      error_count_q <= error_count_d;
    end
  end

  assign out_if.out_valid      = out_valid_q;
  assign out_if.out_data       = out_data_q;
  assign out_if.out_parity_err = out_perr_q;
  assign out_if.out_frame_err  = out_ferr_q;
  assign out_if.out_break      = out_brk_q;
  assign overrun               = overrun_q;
  assign frame_count           = frame_count_q;
  assign error_count           = error_count_q;
endmodule

// File: tb/tb_uart_frame_monitor.sv
// Directed bench for uart_frame_monitor: an 8N1 and a 7E2 instance at 16 clocks per bit.
module tb_uart_frame_monitor;
  import uart_mon_pkg::*;

  localparam int CPB    = 16;
  localparam int LAT_A  = 8 + 9 * CPB + 1;   // HALF + (8 data + 1 stop) bits + 1
  localparam int LAT_B  = 8 + 10 * CPB + 1;  // HALF + (7 data + parity + 2 stop) bits + 1

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rx_a = 1'b1, rx_b = 1'b1;
  logic clr_a = 1'b0, clr_b = 1'b0;
  logic ovr_a, ovr_b;
  logic [15:0] fc_a, ec_a, fc_b, ec_b;
  int cyc = 0;
  int rise_a = -1, rise_b = -1, nrise_a = 0;
  logic pv_a = 1'b0, pv_b = 1'b0;
  int n_cmp = 0, n_err = 0;
  int t0;

  uart_frame_monitor_if #(.DATA_BITS(8)) if_a ();
  uart_frame_monitor_if #(.DATA_BITS(7)) if_b ();

  uart_frame_monitor #(.CLK_FREQ_MHZ(1.0), .BAUD_RATE(62500), .DATA_BITS(8),
                       .PARITY(PAR_NONE), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .uart_rx(rx_a), .out_if(if_a), .overrun(ovr_a),
    .clr_overrun(clr_a), .frame_count(fc_a), .error_count(ec_a));

  uart_frame_monitor #(.CLK_FREQ_MHZ(1.0), .BAUD_RATE(62500), .DATA_BITS(7),
                       .PARITY(PAR_EVEN), .STOP_BITS(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .uart_rx(rx_b), .out_if(if_b), .overrun(ovr_b),
    .clr_overrun(clr_b), .frame_count(fc_b), .error_count(ec_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record the clock count of each out_valid rising edge.
  always @(negedge clk) begin
    if (if_a.out_valid && !pv_a) begin
      rise_a  = cyc;
      nrise_a = nrise_a + 1;
    end
    if (if_b.out_valid && !pv_b) rise_b = cyc;
    pv_a = if_a.out_valid;
    pv_b = if_b.out_valid;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    bit          sel;
    logic [7:0]  d;
    logic        par;
    logic        stopv;
    int          lat;
    logic [7:0]  xd;
    logic        xpe;
    logic        xfe;
    logic        xbk;
    logic [15:0] xfc;
    logic [15:0] xec;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_line(input bit sel, input logic v);
    if (sel) rx_b = v;
    else rx_a = v;
  endtask

  task automatic drive_bit(input bit sel, input logic v);
    set_line(sel, v);
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input logic par, input logic stopv);
    int nb = sel ? 7 : 8;
    int ns = sel ? 2 : 1;
    drive_bit(sel, 1'b0);
    for (int i = 0; i < nb; i++) drive_bit(sel, d[i]);
    if (sel) drive_bit(sel, par);
    for (int i = 0; i < ns; i++) drive_bit(sel, stopv);
    set_line(sel, 1'b1);
  endtask

  function automatic logic get_valid(input bit sel);
    return sel ? if_b.out_valid : if_a.out_valid;
  endfunction

  task automatic wait_valid(input bit sel, input string nm);
    int n = 0;
    while (!get_valid(sel) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " valid"}, 32'(get_valid(sel)), 32'd1);
  endtask

  task automatic accept(input bit sel);
    if (sel) if_b.out_ready = 1'b1;
    else if_a.out_ready = 1'b1;
    @(negedge clk);
    if_a.out_ready = 1'b0;
    if_b.out_ready = 1'b0;
  endtask

  initial begin
    vec_t v;
    if_a.out_ready = 1'b0;
    if_b.out_ready = 1'b0;
    //          sel   d      par   stop  lat    xd     pe    fe    bk    fc     ec
    vt[0]  = '{1'b0, 8'h55, 1'b0, 1'b1, LAT_A, 8'h55, 1'b0, 1'b0, 1'b0, 16'd1, 16'd0};
    vt[1]  = '{1'b0, 8'hA5, 1'b0, 1'b1, LAT_A, 8'hA5, 1'b0, 1'b0, 1'b0, 16'd2, 16'd0};
    vt[2]  = '{1'b0, 8'h3C, 1'b0, 1'b0, LAT_A, 8'h3C, 1'b0, 1'b1, 1'b0, 16'd3, 16'd1};
    vt[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, LAT_A, 8'h00, 1'b0, 1'b0, 1'b0, 16'd4, 16'd1};
    vt[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, LAT_A, 8'h00, 1'b0, 1'b1, 1'b1, 16'd5, 16'd2};
    vt[5]  = '{1'b0, 8'h80, 1'b0, 1'b0, LAT_A, 8'h80, 1'b0, 1'b1, 1'b0, 16'd6, 16'd3};
    vt[6]  = '{1'b1, 8'h41, 1'b1, 1'b1, LAT_B, 8'h41, 1'b1, 1'b0, 1'b0, 16'd1, 16'd1};
    vt[7]  = '{1'b1, 8'h41, 1'b0, 1'b1, LAT_B, 8'h41, 1'b0, 1'b0, 1'b0, 16'd2, 16'd1};
    vt[8]  = '{1'b1, 8'h7F, 1'b1, 1'b1, LAT_B, 8'h7F, 1'b0, 1'b0, 1'b0, 16'd3, 16'd1};
    vt[9]  = '{1'b1, 8'h00, 1'b0, 1'b0, LAT_B, 8'h00, 1'b0, 1'b1, 1'b1, 16'd4, 16'd2};
    vt[10] = '{1'b1, 8'h00, 1'b1, 1'b0, LAT_B, 8'h00, 1'b1, 1'b1, 1'b0, 16'd5, 16'd3};

    chk("cpb_100m_115200", 32'(calc_cpb(100.0, 115200)), 32'd868);
    chk("cpb_bench", 32'(calc_cpb(1.0, 62500)), 32'(CPB));

    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst valid_a", 32'(if_a.out_valid), 32'd0);
    chk("rst data_a", 32'(if_a.out_data), 32'd0);
    chk("rst fc_a", 32'(fc_a), 32'd0);
    chk("rst ec_a", 32'(ec_a), 32'd0);
    chk("rst ovr_a", 32'(ovr_a), 32'd0);
    chk("rst valid_b", 32'(if_b.out_valid), 32'd0);
    repeat (2 * CPB) @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      v = vt[i];
      if (v.sel) rise_b = -1;
      else rise_a = -1;
      t0 = cyc + 1;
      send_frame(v.sel, v.d, v.par, v.stopv);
      wait_valid(v.sel, $sformatf("v%0d", i));
      chk($sformatf("v%0d latency", i), 32'((v.sel ? rise_b : rise_a) - t0), 32'(v.lat));
      chk($sformatf("v%0d data", i), v.sel ? 32'(if_b.out_data) : 32'(if_a.out_data), 32'(v.xd));
      chk($sformatf("v%0d perr", i), 32'(v.sel ? if_b.out_parity_err : if_a.out_parity_err), 32'(v.xpe));
      chk($sformatf("v%0d ferr", i), 32'(v.sel ? if_b.out_frame_err : if_a.out_frame_err), 32'(v.xfe));
      chk($sformatf("v%0d break", i), 32'(v.sel ? if_b.out_break : if_a.out_break), 32'(v.xbk));
      chk($sformatf("v%0d fc", i), 32'(v.sel ? fc_b : fc_a), 32'(v.xfc));
      chk($sformatf("v%0d ec", i), 32'(v.sel ? ec_b : ec_a), 32'(v.xec));
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d hold", i), 32'(get_valid(v.sel)), 32'd1);
      accept(v.sel);
      chk($sformatf("v%0d drop", i), 32'(get_valid(v.sel)), 32'd0);
      drive_bit(v.sel, 1'b1);
      drive_bit(v.sel, 1'b1);
    end

    // Start pulse shorter than half a bit is rejected.
    rx_a = 1'b0;
    repeat (7) @(negedge clk);
    rx_a = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    chk("glitch valid", 32'(if_a.out_valid), 32'd0);
    chk("glitch fc", 32'(fc_a), 32'd6);
    send_frame(1'b0, 8'hA5, 1'b0, 1'b1);
    wait_valid(1'b0, "post_glitch");
    chk("post_glitch data", 32'(if_a.out_data), 32'hA5);
    chk("post_glitch fc", 32'(fc_a), 32'd7);
    accept(1'b0);
    drive_bit(1'b0, 1'b1);

    // Line held low for 20 bit times gives exactly one break frame.
    nrise_a = 0;
    rx_a = 1'b0;
    repeat (20 * CPB) @(negedge clk);
    chk("brk valid", 32'(if_a.out_valid), 32'd1);
    chk("brk break", 32'(if_a.out_break), 32'd1);
    chk("brk ferr", 32'(if_a.out_frame_err), 32'd1);
    chk("brk data", 32'(if_a.out_data), 32'd0);
    accept(1'b0);
    rx_a = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    chk("brk frames", 32'(nrise_a), 32'd1);
    chk("brk fc", 32'(fc_a), 32'd8);
    chk("brk ec", 32'(ec_a), 32'd4);

    // Overrun: second frame dropped while the first is unaccepted.
    send_frame(1'b0, 8'h11, 1'b0, 1'b1);
    drive_bit(1'b0, 1'b1);
    send_frame(1'b0, 8'h22, 1'b0, 1'b1);
    drive_bit(1'b0, 1'b1);
    chk("ovr valid", 32'(if_a.out_valid), 32'd1);
    chk("ovr data", 32'(if_a.out_data), 32'h11);
    chk("ovr flag", 32'(ovr_a), 32'd1);
    chk("ovr fc", 32'(fc_a), 32'd10);
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    chk("ovr clr", 32'(ovr_a), 32'd0);

    // Clear coincident with a new drop: set wins.
    t0 = cyc + 1;
    fork
      send_frame(1'b0, 8'h33, 1'b0, 1'b1);
      begin
        while (cyc != t0 + LAT_A - 1) @(negedge clk);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
      end
    join
    drive_bit(1'b0, 1'b1);
    chk("ovr setwins", 32'(ovr_a), 32'd1);
    chk("ovr setwins data", 32'(if_a.out_data), 32'h11);
    chk("ovr setwins fc", 32'(fc_a), 32'd11);

    // Acceptance coincident with completion: new frame replaces, valid stays high.
    t0 = cyc + 1;
    fork
      send_frame(1'b0, 8'h44, 1'b0, 1'b1);
      begin
        while (cyc != t0 + LAT_A - 1) @(negedge clk);
        if_a.out_ready = 1'b1;
        @(negedge clk);
        if_a.out_ready = 1'b0;
      end
    join
    drive_bit(1'b0, 1'b1);
    chk("replace valid", 32'(if_a.out_valid), 32'd1);
    chk("replace data", 32'(if_a.out_data), 32'h44);
    chk("replace fc", 32'(fc_a), 32'd12);
    chk("replace ec", 32'(ec_a), 32'd4);
    accept(1'b0);
    chk("replace drop", 32'(if_a.out_valid), 32'd0);

    // Reset in the middle of data bit 4 discards the partial frame.
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b0);
    rx_a = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst fc", 32'(fc_a), 32'd0);
    chk("midrst ovr", 32'(ovr_a), 32'd0);
    reset_n = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    chk("midrst valid", 32'(if_a.out_valid), 32'd0);
    rise_a = -1;
    t0 = cyc + 1;
    send_frame(1'b0, 8'h7E, 1'b0, 1'b1);
    wait_valid(1'b0, "midrst_7e");
    chk("midrst latency", 32'(rise_a - t0), 32'(LAT_A));
    chk("midrst data", 32'(if_a.out_data), 32'h7E);
    chk("midrst fc2", 32'(fc_a), 32'd1);
    chk("midrst ec", 32'(ec_a), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
